// File: rtl/aes_disp_pkg.sv
// Shared types and constants for the ciphertext/tag result pager.
package aes_disp_pkg;

    localparam int PAGE_COUNT = 16;
    localparam int WORD_W     = 16;
    localparam int BLOCK_W    = 128;
    localparam int PAGE_W     = $clog2(PAGE_COUNT);
    localparam int SEL_W      = $clog2(2 * BLOCK_W);
    localparam int WORD_SHIFT = $clog2(WORD_W);

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } pager_state_t;

    // Blocks keep the external [0:127] numbering: bit 0 is the MSB.
    typedef logic [0:BLOCK_W-1] block_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [PAGE_W-1:0]  page_t;

    // Pages 0..7 walk the cipher block, pages 8..15 walk the tag block,
    // so the pair is treated as one 256-bit string cut into 16-bit words.
    function automatic word_t select_word(input block_t cipher,
                                          input block_t tag,
                                          input page_t  page);
        logic [0:2*BLOCK_W-1] both;
        logic [SEL_W-1:0]     base;
        both = {cipher, tag};
        base = {page, {WORD_SHIFT{1'b0}}};
        return both[base +: WORD_W];
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for a raw push-button.
module button_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    // The counter only needs to reach DEBOUNCE_CYCLES-1; the sample that
    // would make it DEBOUNCE_CYCLES flips the level instead.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 20'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_count;
    logic             w_differs;
    logic             w_settled;

    assign w_differs = (r_sync2 != r_level);
    assign w_settled = w_differs && (r_count == CNT_LAST);

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so r_sync2 takes the old r_sync1; a blocking
            // assignment here would collapse the two stages into one flop.
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample breaks the run and restarts the count.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_level <= 1'b0;
            r_count <= '0;
        end else if (!w_differs) begin
            r_count <= '0;
        end else if (w_settled) begin
            r_level <= r_sync2;
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_level = r_level;
    // Rise is flagged on the same edge that accepts the new high level, so
    // a consumer acts on that edge rather than one cycle later.
    assign o_rise  = w_settled & r_sync2;

endmodule

// File: rtl/result_pager.sv
// Captures a ciphertext/tag pair and pages through it 16 bits at a time.
module result_pager
    import aes_disp_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [0:BLOCK_W-1] i_cipher_text,
    input  logic [0:BLOCK_W-1] i_tag,
    input  logic               i_tag_ready,
    input  logic               i_btn_next,
    output logic [WORD_W-1:0]  o_data,
    output logic [PAGE_W-1:0]  o_page,
    output logic               o_valid,
    output logic               o_refresh
);

    pager_state_t r_state;
    pager_state_t w_state_next;

    logic   r_tag_ready_d;
    logic   r_armed;
    block_t r_cipher;
    block_t r_tag;
    page_t  r_page;
    word_t  r_data;
    logic   r_valid;
    logic   r_refresh;

    logic   w_btn_level;
    logic   w_btn_rise;
    logic   w_capture;
    logic   w_advance;
    logic   w_load;
    page_t  w_page_inc;
    page_t  w_page_next;
    word_t  w_data_next;
    logic   w_refresh_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .i_reset (i_reset),
        .i_raw   (i_btn_next),
        .o_level (w_btn_level),
        .o_rise  (w_btn_rise)
    );

    // A press counts only while the accepted level is still low, so a held
    // or released button can never re-trigger an advance.
    assign w_advance  = w_btn_rise & ~w_btn_level;

    // A new result is a low-to-high edge of i_tag_ready. r_armed blocks a
    // level that was already high when reset released from looking like an
    // edge: it must be seen low first.
    assign w_capture  = i_tag_ready & ~r_tag_ready_d & r_armed;
    assign w_page_inc = r_page + 1'b1;

    // Remember the previous i_tag_ready and whether it has been low since reset.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_tag_ready_d <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_tag_ready_d <= i_tag_ready;
            if (!i_tag_ready) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Latch both blocks only on a capture edge; later input changes are ignored.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: these wide blocks are ordinary flops, not a RAM array, so
            // they can and do take the asynchronous reset to all zeros.
            r_cipher <= '0;
            r_tag    <= '0;
        end else if (w_load) begin
            r_cipher <= i_cipher_text;
            r_tag    <= i_tag;
        end
    end

    // Next state, page and display word; capture outranks a same-edge press.
    always_comb begin
        // NOTE: every output gets its hold value first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        w_state_next   = r_state;
        w_page_next    = r_page;
        w_data_next    = r_data;
        w_refresh_next = 1'b0;
        w_load         = 1'b0;

        if (w_capture) begin
            w_state_next   = SHOW;
            w_load         = 1'b1;
            w_page_next    = '0;
            w_data_next    = i_cipher_text[0:WORD_W-1];
            w_refresh_next = 1'b1;
        end else begin
            case (r_state)
                SHOW: begin
                    if (w_advance) begin
                        w_page_next    = w_page_inc;
                        w_data_next    = select_word(r_cipher, r_tag, w_page_inc);
                        w_refresh_next = 1'b1;
                    end
                end
                default: begin
                    // EMPTY: presses are ignored until the first capture.
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= EMPTY;
            r_page    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_refresh <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_page    <= w_page_next;
            r_data    <= w_data_next;
            r_valid   <= (w_state_next == SHOW);
            r_refresh <= w_refresh_next;
        end
    end

    assign o_data    = r_data;
    assign o_page    = r_page;
    assign o_valid   = r_valid;
    assign o_refresh = r_refresh;

endmodule

// File: tb/tb_result_pager.sv
// Randomized scoreboard bench for result_pager with a short debounce window.
module tb_result_pager;

    localparam logic [19:0] DB = 20'd4;

    logic         clk = 1'b0;
    logic         i_reset;
    logic [0:127] i_cipher_text;
    logic [0:127] i_tag;
    logic         i_tag_ready;
    logic         i_btn_next;
    logic [15:0]  o_data;
    logic [3:0]   o_page;
    logic         o_valid;
    logic         o_refresh;

    result_pager #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_cipher_text (i_cipher_text),
        .i_tag         (i_tag),
        .i_tag_ready   (i_tag_ready),
        .i_btn_next    (i_btn_next),
        .o_data        (o_data),
        .o_page        (o_page),
        .o_valid       (o_valid),
        .o_refresh     (o_refresh)
    );

    always #5 clk = ~clk;

    int n_pass    = 0;
    int n_total   = 0;
    int n_refresh = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  page;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: the result as one 256-bit string, page as an integer.
    logic [255:0] m_blk   = '0;
    int           m_page  = 0;
    bit           m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] model_word();
        return 16'(m_blk >> (16 * (15 - m_page)));
    endfunction

    task automatic push_expect();
        exp_t e;
        e.data = model_word();
        e.page = 4'(m_page);
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Present a fresh result with a clean low-to-high i_tag_ready edge.
    task automatic do_capture(input logic [127:0] c, input logic [127:0] t);
        i_tag_ready = 1'b0;
        tick(2);
        i_cipher_text = c;
        i_tag         = t;
        m_blk   = {c, t};
        m_page  = 0;
        m_valid = 1'b1;
        push_expect();
        i_tag_ready = 1'b1;
        tick(1);
    endtask

    // Clean press of `hold` cycles then a long release; inputs are scrambled
    // meanwhile to show the latched blocks ignore them.
    task automatic press(input int hold);
        if (m_valid) begin
            m_page = (m_page + 1) % 16;
            push_expect();
        end
        i_btn_next = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (i_tag_ready) begin
                i_cipher_text = rand128();
                i_tag         = rand128();
            end
            tick(1);
        end
        i_btn_next = 1'b0;
        tick(10);
    endtask

    // Monitor: every refresh pulse must match the oldest expectation.
    initial begin
        logic prev_refresh;
        exp_t e;
        prev_refresh = 1'b0;
        forever begin
            @(negedge clk);
            if (o_refresh) begin
                n_refresh++;
                check("refresh_one_cycle", 32'(prev_refresh), 32'd0);
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL refresh_unexpected: o_refresh=1 page=%0d data=0x%04h, expected no pulse (t=%0t)",
                             o_page, o_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", 32'(o_data), 32'(e.data));
                    check("sb_page", 32'(o_page), 32'(e.page));
                    check("sb_valid", 32'(o_valid), 32'd1);
                end
            end
            prev_refresh = o_refresh;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          lat;
        int          n_press;
        logic [127:0] c1;
        logic [127:0] t1;

        i_reset       = 1'b1;
        i_cipher_text = '0;
        i_tag         = '0;
        i_tag_ready   = 1'b0;
        i_btn_next    = 1'b0;
        tick(3);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_page", 32'(o_page), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_refresh", 32'(o_refresh), 32'd0);
        i_reset = 1'b0;
        tick(2);

        // Press before any capture is ignored.
        press(10);
        check("empty_page", 32'(o_page), 32'd0);
        check("empty_valid", 32'(o_valid), 32'd0);
        check("empty_data", 32'(o_data), 32'd0);
        check("empty_no_refresh", 32'(n_refresh), 32'd0);

        // Known-vector capture with exact timing.
        i_tag_ready = 1'b0;
        tick(2);
        i_cipher_text = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        i_tag         = 128'hFEDC_BA98_7654_3210_89AB_CDEF_4567_0123;
        m_blk   = {128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                   128'hFEDC_BA98_7654_3210_89AB_CDEF_4567_0123};
        m_page  = 0;
        m_valid = 1'b1;
        push_expect();
        i_tag_ready = 1'b1;
        tick(1);
        check("cap_data", 32'(o_data), 32'h0011);
        check("cap_page", 32'(o_page), 32'd0);
        check("cap_valid", 32'(o_valid), 32'd1);
        check("cap_refresh", 32'(o_refresh), 32'd1);
        tick(1);
        check("cap_refresh_width", 32'(o_refresh), 32'd0);

        // Sixteen presses walk every word and wrap to page 0.
        base = n_refresh;
        for (int i = 0; i < 16; i++) press(10);
        check("walk_refresh_count", 32'(n_refresh - base), 32'd16);
        check("walk_wrap_data", 32'(o_data), 32'h0011);
        check("walk_wrap_page", 32'(o_page), 32'd0);

        // Bouncing button then steady high: one advance, 6 edges after steady.
        base = n_refresh;
        m_page = (m_page + 1) % 16;
        push_expect();
        for (int i = 0; i < 10; i++) begin
            i_btn_next = (i % 2 == 0);
            tick(1);
        end
        i_btn_next = 1'b1;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!o_refresh && lat < 20);
        check("bounce_latency", 32'(lat), 32'd6);
        tick(10);
        i_btn_next = 1'b0;
        tick(10);
        check("bounce_one_advance", 32'(n_refresh - base), 32'd1);
        check("bounce_page", 32'(o_page), 32'd1);

        // Capture on the same edge as a debounced press: capture wins.
        base = n_refresh;
        i_tag_ready = 1'b0;
        tick(2);
        c1 = rand128();
        t1 = rand128();
        i_btn_next = 1'b1;
        tick(5);
        i_cipher_text = c1;
        i_tag         = t1;
        m_blk  = {c1, t1};
        m_page = 0;
        push_expect();
        i_tag_ready = 1'b1;
        tick(1);
        check("tie_page", 32'(o_page), 32'd0);
        check("tie_data", 32'(o_data), 32'(c1[127:112]));
        tick(8);
        i_btn_next = 1'b0;
        tick(10);
        check("tie_single_refresh", 32'(n_refresh - base), 32'd1);

        // Randomized captures and press runs.
        for (int k = 0; k < 4; k++) begin
            do_capture(rand128(), rand128());
            n_press = $urandom_range(20, 0);
            for (int i = 0; i < n_press; i++) press($urandom_range(20, 8));
            check("rand_page", 32'(o_page), 32'(m_page));
        end

        // Reset at page 5 with i_tag_ready held high and a press in progress.
        do_capture(rand128(), rand128());
        for (int i = 0; i < 5; i++) press(9);
        check("pre_reset_page", 32'(o_page), 32'd5);
        i_btn_next = 1'b1;
        tick(3);
        i_reset    = 1'b1;
        i_btn_next = 1'b0;
        tick(1);
        check("mid_rst_data", 32'(o_data), 32'd0);
        check("mid_rst_page", 32'(o_page), 32'd0);
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_refresh", 32'(o_refresh), 32'd0);
        tick(2);
        i_reset = 1'b0;
        m_valid = 1'b0;
        m_page  = 0;
        m_blk   = '0;
        base = n_refresh;
        tick(6);
        check("post_rst_no_capture", 32'(o_valid), 32'd0);
        press(10);
        check("post_rst_page", 32'(o_page), 32'd0);
        check("post_rst_data", 32'(o_data), 32'd0);
        check("post_rst_no_refresh", 32'(n_refresh - base), 32'd0);
        do_capture(rand128(), rand128());
        tick(1);
        check("post_rst_capture_valid", 32'(o_valid), 32'd1);
        press(12);

        tick(20);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
